// File: rtl/cfa_pkg.sv
// Shared types and widths for the CFA pipeline front end.
// Dimension buses are 11 bits; address_gen forms row*col_max+col in 22 bits.
package cfa_pkg;
    localparam int DIM_W  = 11;
    localparam int ADDR_W = 22;

    typedef enum logic [1:0] {
        CFA_R  = 2'd0,
        CFA_GR = 2'd1,
        CFA_GB = 2'd2,
        CFA_B  = 2'd3
    } cfa_color_t;

    typedef enum logic [1:0] {
        RGGB = 2'd0,
        GRBG = 2'd1,
        GBRG = 2'd2,
        BGGR = 2'd3
    } bayer_pat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } scan_state_t;
endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching `max`; `clr` wins over `en`.
module wrap_counter #(
    parameter int W = cfa_pkg::DIM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         at_max
);
    import cfa_pkg::*;

    assign at_max = (count == max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= at_max ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/cfa_raster_scan.sv
// Raster-order pixel coordinate sequencer with Bayer colour and border sideband.
// Every output is a flop loaded from the next-cycle value computed below.
module cfa_raster_scan #(
    parameter int         DIM_W     = cfa_pkg::DIM_W,
    parameter logic [1:0] BAYER_PAT = 2'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic             ready,
    output logic             valid,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] col_max,
    output logic [1:0]       cfa_color,
    output logic             at_top,
    output logic             at_bottom,
    output logic             at_left,
    output logic             at_right,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import cfa_pkg::*;

    scan_state_t      state, state_nxt;
    logic [DIM_W-1:0] width_r, height_r;
    logic [DIM_W-1:0] col_cnt, row_cnt;
    logic             col_at_max, row_at_max;
    logic             in_scan, accept, start_ok, dim_zero, cnt_clr, row_en, last_pix;

    logic [DIM_W-1:0] width_n, height_n, ncol, nrow;
    logic             scan_n, valid_n, busy_n, done_n, err_n;
    logic             top_n, bottom_n, left_n, right_n, last_n;
    cfa_color_t       color_n;

    assign in_scan  = (state == ST_SCAN);
    assign accept   = in_scan & ready & ~abort;
    assign start_ok = (state == ST_IDLE) & start & ~abort;
    assign dim_zero = (img_width == '0) | (img_height == '0);
    assign last_pix = col_at_max & row_at_max;

    // Counters sit at zero outside SCAN so a new frame always begins at (0,0).
    assign cnt_clr = ~in_scan | abort;
    assign row_en  = col_at_max & accept;

    wrap_counter #(.W(DIM_W)) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept),
        .clr    (cnt_clr),
        .max    (width_r - 1'b1),
        .count  (col_cnt),
        .at_max (col_at_max)
    );

    wrap_counter #(.W(DIM_W)) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (row_en),
        .clr    (cnt_clr),
        .max    (height_r - 1'b1),
        .count  (row_cnt),
        .at_max (row_at_max)
    );

    assign row     = row_cnt;
    assign col     = col_cnt;
    assign col_max = width_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = dim_zero ? ST_FIN : ST_SCAN;
            ST_SCAN: if (accept && last_pix) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort)
            state_nxt = ST_IDLE;
    end

    // Next-cycle coordinate mirrors what the counters will hold after this edge,
    // so the colour/flag flops line up with row/col.
    always_comb begin
        width_n  = start_ok ? img_width  : width_r;
        height_n = start_ok ? img_height : height_r;
        ncol     = col_cnt;
        nrow     = row_cnt;
        if (start_ok) begin
            ncol = '0;
            nrow = '0;
        end else if (accept) begin
            ncol = col_at_max ? '0 : col_cnt + 1'b1;
            nrow = col_at_max ? row_cnt + 1'b1 : row_cnt;
        end
        scan_n   = (state_nxt == ST_SCAN);
        valid_n  = scan_n;
        busy_n   = (state_nxt != ST_IDLE);
        done_n   = (state_nxt == ST_FIN);
        err_n    = start_ok & dim_zero;
        top_n    = scan_n & (nrow == '0);
        bottom_n = scan_n & (nrow == height_n - 1'b1);
        left_n   = scan_n & (ncol == '0);
        right_n  = scan_n & (ncol == width_n - 1'b1);
        last_n   = bottom_n & right_n;
        color_n  = scan_n ? cfa_color_t'({nrow[0], ncol[0]} ^ BAYER_PAT) : CFA_R;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_r   <= '0;
            height_r  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
            at_left   <= 1'b0;
            at_right  <= 1'b0;
            last      <= 1'b0;
            cfa_color <= 2'd0;
        end else begin
            if (start_ok) begin
                width_r  <= img_width;
                height_r <= img_height;
            end
            valid     <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            at_top    <= top_n;
            at_bottom <= bottom_n;
            at_left   <= left_n;
            at_right  <= right_n;
            last      <= last_n;
            cfa_color <= color_n;
        end
    end
endmodule

// File: doc/cfa_raster_scan.md
# cfa_raster_scan

Raster-scan sequencer for the CFA pipeline; sits directly upstream of `address_gen`. On a start request it latches the frame dimensions and issues every pixel coordinate (row, col) in raster order over a valid/ready handshake. Alongside each coordinate it supplies `col_max` for address generation, the Bayer colour of the site, and frame-border flags used by the demosaic window logic. It pulses `done` when the frame is fully issued.

## Interface
- `DIM_W`, 11: width of row/col/dimension buses; `address_gen` consumes 11-bit row/col/col_max.
- `BAYER_PAT`, 2'd0: phase of the sensor's R site. 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: frame request; sampled only in IDLE.
- `abort` in 1: synchronous cancel of the current frame.
- `img_width` in DIM_W: columns per row; latched at start.
- `img_height` in DIM_W: rows per frame; latched at start.
- `ready` in 1: downstream accepts the current coordinate.
- `valid` out 1: `row`/`col` and the sideband outputs are valid.
- `row` out DIM_W: current row, 0..height-1.
- `col` out DIM_W: current column, 0..width-1.
- `col_max` out DIM_W: latched width; feeds `address_gen.col_max`.
- `cfa_color` out 2: 0=R, 1=G on R row, 2=G on B row, 3=B.
- `at_top`, `at_bottom`, `at_left`, `at_right` out 1 each: border flags.
- `last` out 1: final pixel of the frame.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle end-of-frame pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, when a dimension is zero.

## Operation
- States and transitions:
  - IDLE, on `start` & !`abort`: go to SCAN if both dimensions are nonzero, otherwise go to FIN with `err`.
  - SCAN, on `valid`&`ready`: advance the coordinate. From the last pixel, go to FIN.
  - FIN: drive `done` (and `err` if flagged) for one cycle, then return to IDLE.
  - Any state, on `abort`: go to IDLE next cycle with no `done`.
- Coordinate advance: `col` increments. When `col` = width-1 it wraps to 0 and `row` increments. `row` never wraps within a frame.
- `valid` is high for every SCAN cycle. While `valid` & !`ready`, all outputs hold stable (AXI-style: no retraction, no change).
- Colour: `cfa_color` = {row[0], col[0]} XOR `BAYER_PAT`.
- Border flags:
  - `at_top` = (row==0); `at_bottom` = (row==height-1).
  - `at_left` = (col==0); `at_right` = (col==width-1).
  - `last` = `at_bottom` & `at_right`.
- A 1×1 frame asserts all four border flags and `last` on its single pixel.
- `start` while `busy` is ignored and not queued. `img_width`/`img_height` changes after the start cycle have no effect.
- `abort` has priority over `start` and over a handshake in the same cycle; that pixel counts as not accepted.
- Reset values: state IDLE; `row`, `col`, `col_max` = 0; `cfa_color` = 0; all 1-bit outputs = 0. Reset mid-frame discards the frame and raises no `done`.
- Maximum frame is 2047×2047. Product row*col_max+col fits in 22 bits downstream.

## Timing
- All outputs are registered; no combinational path from input to output.
- `start` accepted in cycle N: `valid` with (0,0) in cycle N+1, and `busy` rises in N+1.
- Throughput is one pixel per cycle with `ready` held high. A W×H frame occupies W*H SCAN cycles.
- Last handshake in cycle M: `valid`=0 and `done`=1 in M+1, `busy`=0 in M+2. A new `start` is accepted in M+2.
- Zero-dimension start in cycle N: `done`=`err`=1 in N+1 and `valid` is never asserted.
- `abort` in cycle N: `valid`=`busy`=0 in N+1.

## Structure
- Shared package `cfa_pkg` holds:
  - `DIM_W`=11 and `ADDR_W`=22;
  - the `cfa_color_t` encoding (R, GR, GB, B);
  - the `bayer_pat_t` codes (RGGB, GRBG, GBRG, BGGR).
- One sub-module, `wrap_counter`: a DIM_W counter with `en`, `clr`, and a `max` input, producing `count` and `at_max`. Instantiate it twice, with the column `at_max`&`en` driving the row `en`.
- The FSM, the output registers and the colour/flag logic live in the top.

## Test plan
- 4×3 frame, RGGB, `ready`=1:
  - 12 beats (0,0)…(2,3);
  - colours R,G,R,G / G,B,G,B / R,G,R,G, i.e. 0,1,0,1 / 2,3,2,3 / 0,1,0,1;
  - `last` only on (2,3);
  - `done` one cycle after the final beat;
  - `col_max`=4 throughout.
- Same frame with pseudo-random `ready` and `BAYER_PAT`=3: sequence identical in order, outputs stable during stalls, (0,0) colour = B.
- `img_width`=0, `img_height`=5: no `valid`; `done`=`err`=1 on the cycle after start.
- 1×1 frame: single beat with all border flags and `last` set, then `done`.
- Abort at (1,2) of an 8×8 frame with `ready` high: `valid`=0 next cycle, no `done`. A new start for 2×2 then yields (0,0)…(1,1) correctly.
- `start` pulses mid-frame, and `rst_n` low mid-frame: the pulses are ignored. The reset drives all outputs to their reset values immediately, without waiting for a clock edge.
